// File: rtl/bomb_pkg.sv
// Shared occupancy/grid code definitions for the bomb game datapath.
package bomb_pkg;

  localparam int OCC_BITS = 4;

  typedef logic [OCC_BITS-1:0] occ_t;
  typedef logic [2:0]          gadget_t;
  typedef logic [2:0]          bomb_t;
  typedef logic [1:0]          wall_t;

  localparam occ_t OCC_NONE      = 4'd0;
  localparam occ_t OCC_LOTION    = 4'd1;
  localparam occ_t OCC_BOMB      = 4'd2;
  localparam occ_t OCC_ADD_BOMB  = 4'd3;
  localparam occ_t OCC_CEN       = 4'd4;
  localparam occ_t OCC_UP        = 4'd5;
  localparam occ_t OCC_DOWN      = 4'd6;
  localparam occ_t OCC_LEFT      = 4'd7;
  localparam occ_t OCC_RIGHT     = 4'd8;
  localparam occ_t OCC_WALL_ABLE = 4'd9;
  localparam occ_t OCC_WALL_UN   = 4'd10;

  localparam wall_t EMPTY_WALL = 2'd0;
  localparam wall_t ABLE_WALL  = 2'd1;
  localparam wall_t UN_WALL    = 2'd2;

  localparam gadget_t GADGET_NONE = 3'd0;
  localparam gadget_t LOTION      = 3'd1;
  localparam gadget_t ADD_BOMB    = 3'd2;

  localparam bomb_t BOMB_EMPTY = 3'd0;
  localparam bomb_t READY_EXP  = 3'd1;
  localparam bomb_t BOMB_UN    = 3'd2;
  localparam bomb_t EXP_UP     = 3'd3;
  localparam bomb_t EXP_DOWN   = 3'd4;
  localparam bomb_t EXP_LEFT   = 3'd5;
  localparam bomb_t EXP_RIGHT  = 3'd6;
  localparam bomb_t EXP_CEN    = 3'd7;

  typedef enum logic [1:0] {IDLE, SCAN, SWAP} scan_state_t;

endpackage

// File: rtl/occ_cell_encode.sv
// Combinational priority encoder from one cell's gadget/bomb/wall codes to its occupancy code.
module occ_cell_encode
  import bomb_pkg::*;
(
  input  gadget_t gadget,
  input  bomb_t   bomb,
  input  wall_t   wall,
  input  occ_t    held,
  output occ_t    occ
);

  always_comb begin
    occ = OCC_NONE;
    if (wall == UN_WALL) begin
      occ = OCC_WALL_UN;
    end else begin
      case (bomb)
        BOMB_UN:   occ = OCC_BOMB;
        EXP_UP:    occ = OCC_UP;
        EXP_DOWN:  occ = OCC_DOWN;
        EXP_LEFT:  occ = OCC_LEFT;
        EXP_RIGHT: occ = OCC_RIGHT;
        EXP_CEN:   occ = OCC_CEN;
        READY_EXP: occ = held;
        default: begin
          // Wall code 3 falls through here and behaves like an empty wall.
          if (wall == ABLE_WALL)      occ = OCC_WALL_ABLE;
          else if (gadget == LOTION)   occ = OCC_LOTION;
          else if (gadget == ADD_BOMB) occ = OCC_ADD_BOMB;
          else                         occ = OCC_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/occ_scan_composer.sv
// Time-multiplexed occupancy composer: scans the grids LANES cells per cycle into a
// back bank, then swaps banks so the renderer always reads a complete frame.
module occ_scan_composer
  import bomb_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int LANES  = 1,
  parameter int OCC_W  = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  gadget_t                              gadget_grid [0:GRID_W*GRID_H-1],
  input  bomb_t                                bomb_grid   [0:GRID_W*GRID_H-1],
  input  wall_t                                wall_grid   [0:GRID_W*GRID_H-1],
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0]   frame_changes,
  input  logic [$clog2(GRID_W*GRID_H)-1:0]     rd_addr,
  output logic [OCC_W-1:0]                     rd_data
);

  localparam int N  = GRID_W * GRID_H;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  if (N % LANES != 0) begin : g_bad_lanes
    $error("occ_scan_composer: LANES must divide GRID_W*GRID_H");
  end
  if (OCC_W < OCC_BITS) begin : g_bad_occ_w
    $error("occ_scan_composer: OCC_W too narrow for occupancy codes");
  end

  scan_state_t     state;
  logic            bank_sel;
  logic            back_sel;
  occ_t            bank [0:1][0:N-1];
  logic [AW-1:0]   idx;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   diff;
  logic            addr_ok;
  logic [AW-1:0]   lane_addr  [LANES];
  occ_t            lane_code  [LANES];
  occ_t            lane_front [LANES];

  assign back_sel = ~bank_sel;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_addr[l]  = idx + AW'(l);
    assign lane_front[l] = bank[bank_sel][lane_addr[l]];
    occ_cell_encode u_enc (
      .gadget (gadget_grid[lane_addr[l]]),
      .bomb   (bomb_grid[lane_addr[l]]),
      .wall   (wall_grid[lane_addr[l]]),
      .held   (lane_front[l]),
      .occ    (lane_code[l])
    );
  end

  // Only non-power-of-two grids can present an address past the last cell.
  if ((2 ** AW) > N) begin : g_addr_range
    assign addr_ok = (rd_addr < AW'(N));
  end else begin : g_addr_full
    assign addr_ok = 1'b1;
  end

  always_comb begin
    diff = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane_code[l] != lane_front[l]) diff = diff + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bank_sel      <= 1'b0;
      bank          <= '{default: OCC_NONE};
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_changes <= '0;
      rd_data       <= '0;
      idx           <= '0;
      acc           <= '0;
    end else begin
      done    <= 1'b0;
      rd_data <= addr_ok ? OCC_W'(bank[bank_sel][rd_addr]) : '0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
            idx   <= '0;
            acc   <= '0;
          end
        end
        SCAN: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            bank[back_sel][lane_addr[l]] <= lane_code[l];
          end
          acc <= acc + diff;
          if (idx == AW'(N - LANES)) begin
            state <= SWAP;
            done  <= 1'b1;
          end else begin
            idx <= idx + AW'(LANES);
          end
        end
        SWAP: begin
          bank_sel      <= ~bank_sel;
          frame_changes <= acc;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
